// File: rtl/fm_mem_pkg.sv
// rtl/fm_mem_pkg.sv - shared types for the feature-map memory arbiter
package fm_mem_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CONV = 2'd1,
    OWN_FC   = 2'd2,
    OWN_HOST = 2'd3
  } owner_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GRANT_CONV = 3'd1,
    GRANT_FC   = 3'd2,
    GRANT_HOST = 3'd3,
    DRAIN      = 3'd4
  } arb_state_e;

  function automatic owner_e state_owner(arb_state_e s);
    case (s)
      GRANT_CONV: return OWN_CONV;
      GRANT_FC:   return OWN_FC;
      GRANT_HOST: return OWN_HOST;
      default:    return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fm_mem_arbiter_if.sv
// rtl/fm_mem_arbiter_if.sv - requester and memory port bundles of the arbiter
// Host signals exist only when MEM_ARB_HOST_PORT_EN is defined.
interface fm_mem_arbiter_if #(
  parameter int ADDRESS_BITS = 16,
  parameter int COLS_MAC     = 4,
  parameter int INPUTS_MAC   = 6
);
  localparam int DW = fm_mem_pkg::DATA_BITS;

  logic                                      conv_req;
  logic                                      conv_gnt;
  logic [COLS_MAC-1:0]                       conv_en_w;
  logic [COLS_MAC-1:0][DW-1:0]               conv_of_write;
  logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]     conv_of_w_address;
  logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0]   conv_if_address;

  logic                                      fc_req;
  logic                                      fc_gnt;
  logic [COLS_MAC-1:0]                       fc_en_w;
  logic [COLS_MAC-1:0][DW-1:0]               fc_of_write;
  logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]     fc_of_w_address;
  logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0]   fc_if_address;

`ifdef MEM_ARB_HOST_PORT_EN
  logic                                      host_req;
  logic                                      host_gnt;
  logic                                      host_en_w;
  logic [DW-1:0]                             host_of_write;
  logic [ADDRESS_BITS-1:0]                   host_of_w_address;
`endif

  logic [COLS_MAC-1:0]                       mem_en_w;
  logic [COLS_MAC-1:0][DW-1:0]               mem_of_write;
  logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]     mem_of_w_address;
  logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0]   mem_if_address;

  modport master (
`ifdef MEM_ARB_HOST_PORT_EN
    output host_req, host_en_w, host_of_write, host_of_w_address,
    input  host_gnt,
`endif
    output conv_req, conv_en_w, conv_of_write, conv_of_w_address, conv_if_address,
    output fc_req, fc_en_w, fc_of_write, fc_of_w_address, fc_if_address,
    input  conv_gnt, fc_gnt,
    input  mem_en_w, mem_of_write, mem_of_w_address, mem_if_address
  );

  modport slave (
`ifdef MEM_ARB_HOST_PORT_EN
    input  host_req, host_en_w, host_of_write, host_of_w_address,
    output host_gnt,
`endif
    input  conv_req, conv_en_w, conv_of_write, conv_of_w_address, conv_if_address,
    input  fc_req, fc_en_w, fc_of_write, fc_of_w_address, fc_if_address,
    output conv_gnt, fc_gnt,
    output mem_en_w, mem_of_write, mem_of_w_address, mem_if_address
  );

endinterface

// File: rtl/fm_mem_port_mux.sv
// rtl/fm_mem_port_mux.sv - combinational owner-to-memory bundle select
// Host lane-0 path present only with MEM_ARB_HOST_PORT_EN.
module fm_mem_port_mux
  import fm_mem_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int COLS_MAC     = 4,
  parameter int INPUTS_MAC   = 6
) (
  input  owner_e                                    owner,
  input  logic [COLS_MAC-1:0]                       conv_en_w,
  input  logic [COLS_MAC-1:0][DATA_BITS-1:0]        conv_of_write,
  input  logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]     conv_of_w_address,
  input  logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0]   conv_if_address,
  input  logic [COLS_MAC-1:0]                       fc_en_w,
  input  logic [COLS_MAC-1:0][DATA_BITS-1:0]        fc_of_write,
  input  logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]     fc_of_w_address,
  input  logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0]   fc_if_address,
`ifdef MEM_ARB_HOST_PORT_EN
  input  logic                                      host_en_w,
  input  logic [DATA_BITS-1:0]                      host_of_write,
  input  logic [ADDRESS_BITS-1:0]                   host_of_w_address,
`endif
  output logic [COLS_MAC-1:0]                       mem_en_w,
  output logic [COLS_MAC-1:0][DATA_BITS-1:0]        mem_of_write,
  output logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]     mem_of_w_address,
  output logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0]   mem_if_address
);

  // Unowned and draining periods present an all-zero bundle so no stray write lands.
  always_comb begin
    mem_en_w         = '0;
    mem_of_write     = '0;
    mem_of_w_address = '0;
    mem_if_address   = '0;
    case (owner)
      OWN_CONV: begin
        mem_en_w         = conv_en_w;
        mem_of_write     = conv_of_write;
        mem_of_w_address = conv_of_w_address;
        mem_if_address   = conv_if_address;
      end
      OWN_FC: begin
        mem_en_w         = fc_en_w;
        mem_of_write     = fc_of_write;
        mem_of_w_address = fc_of_w_address;
        mem_if_address   = fc_if_address;
      end
`ifdef MEM_ARB_HOST_PORT_EN
      OWN_HOST: begin
        mem_en_w[0]         = host_en_w;
        mem_of_write[0]     = host_of_write;
        mem_of_w_address[0] = host_of_w_address;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/fm_mem_arbiter.sv
// rtl/fm_mem_arbiter.sv - round-robin owner arbiter for the shared feature-map memory port
// Optional host requester with strict IDLE priority under MEM_ARB_HOST_PORT_EN.
module fm_mem_arbiter
  import fm_mem_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int COLS_MAC     = 4,
  parameter int INPUTS_MAC   = 6,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  fm_mem_arbiter_if.slave   bus,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              proto_err
);

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  arb_state_e state, state_nxt;
  owner_e     last_owner, last_owner_nxt;
  owner_e     owner_q, owner_nxt;
  logic [7:0] drain_cnt, drain_cnt_nxt;
  logic       conv_gnt_q, fc_gnt_q;
  logic       stray_write;
`ifdef MEM_ARB_HOST_PORT_EN
  logic       host_gnt_q;
`endif

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    drain_cnt_nxt  = drain_cnt;
    case (state)
      IDLE: begin
`ifdef MEM_ARB_HOST_PORT_EN
        if (bus.host_req) begin
          state_nxt = GRANT_HOST;
        end else
`endif
        // On a tie the engine that did not own the port last time wins.
        if (bus.conv_req && (!bus.fc_req || last_owner == OWN_FC)) begin
          state_nxt      = GRANT_CONV;
          last_owner_nxt = OWN_CONV;
        end else if (bus.fc_req) begin
          state_nxt      = GRANT_FC;
          last_owner_nxt = OWN_FC;
        end
      end
      GRANT_CONV: begin
        if (!bus.conv_req) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
      end
      GRANT_FC: begin
        if (!bus.fc_req) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
      end
`ifdef MEM_ARB_HOST_PORT_EN
      GRANT_HOST: begin
        if (!bus.host_req) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
      end
`endif
      DRAIN: begin
        if (drain_cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          drain_cnt_nxt = drain_cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    owner_nxt = state_owner(state_nxt);
  end

  always_comb begin
    stray_write = ((|bus.conv_en_w) && !conv_gnt_q) || ((|bus.fc_en_w) && !fc_gnt_q);
`ifdef MEM_ARB_HOST_PORT_EN
    stray_write = stray_write || (bus.host_en_w && !host_gnt_q);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= OWN_FC;
      owner_q    <= OWN_NONE;
      drain_cnt  <= '0;
      conv_gnt_q <= 1'b0;
      fc_gnt_q   <= 1'b0;
      proto_err  <= 1'b0;
`ifdef MEM_ARB_HOST_PORT_EN
      host_gnt_q <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      owner_q    <= owner_nxt;
      drain_cnt  <= drain_cnt_nxt;
      conv_gnt_q <= (owner_nxt == OWN_CONV);
      fc_gnt_q   <= (owner_nxt == OWN_FC);
      proto_err  <= proto_err || stray_write;
`ifdef MEM_ARB_HOST_PORT_EN
      host_gnt_q <= (owner_nxt == OWN_HOST);
`endif
    end
  end

  assign bus.conv_gnt = conv_gnt_q;
  assign bus.fc_gnt   = fc_gnt_q;
`ifdef MEM_ARB_HOST_PORT_EN
  assign bus.host_gnt = host_gnt_q;
`endif
  assign owner = owner_q;
  assign busy  = (owner_q != OWN_NONE) || (state == DRAIN);

  fm_mem_port_mux #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .COLS_MAC     (COLS_MAC),
    .INPUTS_MAC   (INPUTS_MAC)
  ) u_mux (
    .owner             (owner_q),
    .conv_en_w         (bus.conv_en_w),
    .conv_of_write     (bus.conv_of_write),
    .conv_of_w_address (bus.conv_of_w_address),
    .conv_if_address   (bus.conv_if_address),
    .fc_en_w           (bus.fc_en_w),
    .fc_of_write       (bus.fc_of_write),
    .fc_of_w_address   (bus.fc_of_w_address),
    .fc_if_address     (bus.fc_if_address),
`ifdef MEM_ARB_HOST_PORT_EN
    .host_en_w         (bus.host_en_w),
    .host_of_write     (bus.host_of_write),
    .host_of_w_address (bus.host_of_w_address),
`endif
    .mem_en_w          (bus.mem_en_w),
    .mem_of_write      (bus.mem_of_write),
    .mem_of_w_address  (bus.mem_of_w_address),
    .mem_if_address    (bus.mem_if_address)
  );

endmodule
